plic_core: RTL and testbench

- Interrupt gateway and arbitration core of the PLIC. Sits directly downstream of the PLIC register file.
- Consumes from the register file: edge/level select, enable, packed priorities, threshold, and claim/complete pulses.
- Returns the winning interrupt ID to the register file for claim reads, and drives the machine external interrupt request to the hart.
- Handles 15 sources (IDs 1..15; source bit i maps to ID i+1). ID 0 means "no interrupt".

---
 rtl/plic_core.sv | 110 +++++++++++
 tb/tb_plic_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/plic_core.sv
// PLIC gateway and arbitration core: per-source edge/level gateways, priority
// arbitration against a threshold, and a single claim/complete in-service slot.
module plic_core #(
    parameter int unsigned NSRC   = 15,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC-1:0]          irq_src,
    input  logic [NSRC-1:0]          el,
    input  logic [NSRC-1:0]          ie,
    input  logic [NSRC*PRIO_W-1:0]   pw,
    input  logic [PRIO_W-1:0]        th,
    input  logic                     claim,
    input  logic                     complete,
    output logic [ID_W-1:0]          id,
    output logic                     eip,
    output logic [NSRC-1:0]          pending
);

    typedef enum logic [1:0] {GwIdle, GwPend, GwInfl} gw_state_e;

    gw_state_e         gw_q [NSRC];
    gw_state_e         gw_d [NSRC];
    logic [NSRC-1:0]   defer_q, defer_d;
    logic [NSRC-1:0]   src_q, src_qq;
    logic [NSRC-1:0]   rise, trig;
    logic [ID_W-1:0]   in_service_q, in_service_d;
    logic [ID_W-1:0]   winner, id_d;
    logic              eip_d;
    logic              claim_ok;
    logic [PRIO_W-1:0] prio, best_prio;
    logic [ID_W-1:0]   best_id;

    assign rise     = src_q & ~src_qq;
    assign trig     = (el & rise) | (~el & src_q);
    // id is forced to 0 while a source is in service, so a claim there is a no-op
    assign claim_ok = claim && (id != '0);

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            gw_d[i]    = gw_q[i];
            defer_d[i] = defer_q[i];
            pending[i] = (gw_q[i] == GwPend);
            unique case (gw_q[i])
                GwIdle: begin
                    if (trig[i]) gw_d[i] = GwPend;
                end
                GwPend: begin
                    if (claim_ok && id == ID_W'(i + 1)) gw_d[i] = GwInfl;
                end
                GwInfl: begin
                    if (complete && in_service_q == ID_W'(i + 1)) begin
                        // an edge landing on the completing cycle counts as deferred
                        gw_d[i]    = (defer_q[i] || (el[i] && rise[i])) ? GwPend : GwIdle;
                        defer_d[i] = 1'b0;
                    end else if (el[i] && rise[i]) begin
                        defer_d[i] = 1'b1;
                    end
                end
                default: gw_d[i] = GwIdle;
            endcase
        end
    end

    // Ascending scan with strict compare keeps the lowest ID on priority ties.
    always_comb begin
        best_prio = '0;
        best_id   = '0;
        prio      = '0;
        for (int i = 0; i < NSRC; i++) begin
            prio = pw[i*PRIO_W +: PRIO_W];
            if (pending[i] && ie[i] && (prio > th) && (prio > best_prio)) begin
                best_prio = prio;
                best_id   = ID_W'(i + 1);
            end
        end
        winner = (in_service_q != '0) ? '0 : best_id;
    end

    always_comb begin
        in_service_d = in_service_q;
        if (complete) in_service_d = '0;
        if (claim_ok) in_service_d = id;
        id_d  = claim_ok ? '0 : winner;
        eip_d = (id_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q        <= '0;
            src_qq       <= '0;
            defer_q      <= '0;
            in_service_q <= '0;
            id           <= '0;
            eip          <= 1'b0;
            for (int i = 0; i < NSRC; i++) gw_q[i] <= GwIdle;
        end else begin
            src_q        <= irq_src;
            src_qq       <= src_q;
            defer_q      <= defer_d;
            in_service_q <= in_service_d;
            id           <= id_d;
            eip          <= eip_d;
            for (int i = 0; i < NSRC; i++) gw_q[i] <= gw_d[i];
        end
    end

endmodule

// File: tb/tb_plic_core.sv
// Directed bench for plic_core: gateway latency, arbitration, threshold,
// edge deferral, claim/complete corner cases and mid-operation reset.
module tb_plic_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] irq_src, el, ie;
    logic [44:0] pw;
    logic [2:0]  th;
    logic        claim, complete;
    logic [3:0]  id;
    logic        eip;
    logic [14:0] pending;

    int n_vec = 0;
    int n_err = 0;

    plic_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_src  (irq_src),
        .el       (el),
        .ie       (ie),
        .pw       (pw),
        .th       (th),
        .claim    (claim),
        .complete (complete),
        .id       (id),
        .eip      (eip),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_prio(input int src, input logic [2:0] p);
        pw[src*3 +: 3] = p;
    endtask

    task automatic do_reset();
        irq_src = '0; el = '0; ie = '0; pw = '0; th = '0;
        claim = 1'b0; complete = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_claim();
        claim = 1'b1; tick(); claim = 1'b0;
    endtask

    task automatic pulse_complete();
        complete = 1'b1; tick(); complete = 1'b0;
    endtask

    task automatic pulse_src(input int src);
        irq_src[src] = 1'b1; tick(); irq_src[src] = 1'b0; tick();
    endtask

    initial begin
        do_reset();
        check("rst_id", id, 0);
        check("rst_eip", eip, 0);
        check("rst_pending", pending, 0);

        // Level source 3 (ID 4), P=5, th=2
        set_prio(3, 5); th = 3'd2; ie[3] = 1'b1;
        irq_src[3] = 1'b1;
        tick();
        check("lvl_pend_lat1", pending, 0);
        tick();
        check("lvl_pend", pending, 15'h0008);
        check("lvl_id_early", id, 0);
        tick();
        check("lvl_id", id, 4);
        check("lvl_eip", eip, 1);
        pulse_claim();
        check("lvl_claim_id", id, 0);
        check("lvl_claim_eip", eip, 0);
        check("lvl_claim_pend", pending, 0);
        tick();
        check("lvl_insvc_id", id, 0);
        pulse_complete();
        check("lvl_cmp_pend", pending, 0);
        tick();
        check("lvl_repend", pending, 15'h0008);
        tick();
        check("lvl_reid", id, 4);

        // Priority and tie-break
        do_reset();
        ie = '1; th = 3'd0;
        set_prio(1, 4); set_prio(5, 6); set_prio(9, 6);
        irq_src[1] = 1'b1; irq_src[5] = 1'b1; irq_src[9] = 1'b1;
        tick(3);
        check("tie_id", id, 6);
        set_prio(5, 3);
        tick();
        check("prio_id", id, 10);
        check("prio_eip", eip, 1);

        // Threshold is strict; ie gating retains pending
        do_reset();
        set_prio(0, 2); th = 3'd2; ie[0] = 1'b1; irq_src[0] = 1'b1;
        tick(3);
        check("th_pend", pending, 15'h0001);
        check("th_eq_id", id, 0);
        check("th_eq_eip", eip, 0);
        th = 3'd1;
        tick();
        check("th_lo_id", id, 1);
        ie[0] = 1'b0;
        tick();
        check("ie_off_id", id, 0);
        check("ie_off_pend", pending, 15'h0001);
        ie[0] = 1'b1;
        tick();
        check("ie_on_id", id, 1);

        // Edge mode with deferral, source 7 (ID 8)
        do_reset();
        el[7] = 1'b1; ie[7] = 1'b1; set_prio(7, 3);
        pulse_src(7);
        check("edge_pend", pending, 15'h0080);
        tick();
        check("edge_id", id, 8);
        pulse_claim();
        check("edge_claim_pend", pending, 0);
        pulse_src(7);
        tick();
        check("edge_defer_pend", pending, 0);
        check("edge_defer_id", id, 0);
        pulse_complete();
        check("edge_cmp_pend", pending, 15'h0080);
        check("edge_cmp_id", id, 0);
        tick();
        check("edge_re_id", id, 8);
        pulse_src(7);
        tick();
        pulse_claim();
        check("edge_c2_id", id, 0);
        pulse_complete();
        tick(2);
        check("edge_merge_pend", pending, 0);
        check("edge_merge_id", id, 0);

        // Claim with id=0, complete with nothing in service, claim+complete together
        do_reset();
        pulse_claim();
        check("nop_claim_id", id, 0);
        check("nop_claim_pend", pending, 0);
        ie = '1; set_prio(2, 3); set_prio(10, 2);
        irq_src[2] = 1'b1; irq_src[10] = 1'b1;
        tick(3);
        check("cc_id", id, 3);
        pulse_complete();
        check("nop_cmp_id", id, 3);
        check("nop_cmp_pend", pending, 15'h0404);
        pulse_claim();
        irq_src[2] = 1'b0;
        check("cc_claim_id", id, 0);
        check("cc_claim_pend", pending, 15'h0400);
        tick();
        check("cc_mask_id", id, 0);
        claim = 1'b1; complete = 1'b1;
        tick();
        claim = 1'b0; complete = 1'b0;
        check("cc_both_id", id, 0);
        check("cc_both_pend", pending, 15'h0400);
        tick();
        check("cc_next_id", id, 11);
        check("cc_next_pend", pending, 15'h0400);

        // Reset mid-operation
        do_reset();
        ie = '1; set_prio(4, 5); set_prio(6, 3);
        irq_src[4] = 1'b1; irq_src[6] = 1'b1;
        tick(3);
        check("mr_id", id, 5);
        pulse_claim();
        check("mr_insvc_pend", pending, 15'h0040);
        irq_src[4] = 1'b0;
        rst_n = 1'b0; claim = 1'b1;
        tick();
        rst_n = 1'b1; claim = 1'b0;
        check("mr_rst_id", id, 0);
        check("mr_rst_eip", eip, 0);
        check("mr_rst_pend", pending, 0);
        tick();
        check("mr_lat_pend", pending, 0);
        tick();
        check("mr_repend", pending, 15'h0040);
        tick();
        check("mr_reid", id, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
